// File: rtl/rv32_bus_arbiter_if.sv
// Fetch port, load/store port and shared memory bus of the RV32 bus arbiter.
// The arbiter takes the slave view; the core and the memory take the master view.
interface rv32_bus_arbiter_if;
  logic        instr_read_in;
  logic [31:0] instr_address_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic        instr_fault_out;

  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_address_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic        data_fault_out;

  logic        mem_valid_out;
  logic        mem_write_out;
  logic [3:0]  mem_write_mask_out;
  logic [31:0] mem_address_out;
  logic [31:0] mem_write_value_out;
  logic        mem_ready_in;
  logic [31:0] mem_read_value_in;

  modport slave (
    input  instr_read_in, instr_address_in,
    output instr_read_value_out, instr_ready_out, instr_fault_out,
    input  data_read_in, data_write_in, data_write_mask_in, data_address_in, data_write_value_in,
    output data_read_value_out, data_ready_out, data_fault_out,
    output mem_valid_out, mem_write_out, mem_write_mask_out, mem_address_out, mem_write_value_out,
    input  mem_ready_in, mem_read_value_in
  );

  modport master (
    output instr_read_in, instr_address_in,
    input  instr_read_value_out, instr_ready_out, instr_fault_out,
    output data_read_in, data_write_in, data_write_mask_in, data_address_in, data_write_value_in,
    input  data_read_value_out, data_ready_out, data_fault_out,
    input  mem_valid_out, mem_write_out, mem_write_mask_out, mem_address_out, mem_write_value_out,
    output mem_ready_in, mem_read_value_in
  );
endinterface

// File: rtl/rv32_bus_arbiter.sv
// Round-robin arbiter merging fetch and load/store requests onto one memory bus;
// an access with no mem_ready_in for TIMEOUT_CYCLES busy cycles completes with a fault.
module rv32_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  rv32_bus_arbiter_if.slave bus
);

  localparam logic [1:0]  ST_IDLE      = 2'd0;
  localparam logic [1:0]  ST_BUSY      = 2'd1;
  localparam logic [1:0]  ST_DONE      = 2'd2;
  localparam logic        OWN_INSTR    = 1'b0;
  localparam logic        OWN_DATA     = 1'b1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic        owner;
  logic        last_grant;
  logic [15:0] tmo_cnt;
  logic        cmd_write;
  logic [3:0]  cmd_mask;
  logic [31:0] cmd_address;
  logic [31:0] cmd_write_value;
  logic [31:0] instr_value;
  logic [31:0] data_value;
  logic        resp_fault;

  logic instr_req;
  logic data_req;
  logic data_is_write;
  logic grant_data;
  logic busy;
  logic done;
  logic finish;
  logic [31:0] resp_value;

  assign instr_req     = bus.instr_read_in;
  assign data_is_write = bus.data_write_in;
  assign data_req      = bus.data_read_in | bus.data_write_in;
  // On a tie the side that did not win the previous grant goes first.
  assign grant_data    = data_req & (~instr_req | (last_grant == OWN_INSTR));

  assign busy       = (state == ST_BUSY);
  assign done       = (state == ST_DONE);
  assign finish     = bus.mem_ready_in | (tmo_cnt == TIMEOUT_LAST);
  assign resp_value = bus.mem_ready_in ? bus.mem_read_value_in : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      owner           <= OWN_INSTR;
      last_grant      <= OWN_INSTR;
      tmo_cnt         <= 16'h0;
      cmd_write       <= 1'b0;
      cmd_mask        <= 4'h0;
      cmd_address     <= 32'h0;
      cmd_write_value <= 32'h0;
      instr_value     <= 32'h0;
      data_value      <= 32'h0;
      resp_fault      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_req | data_req) begin
            state      <= ST_BUSY;
            tmo_cnt    <= 16'h0;
            owner      <= grant_data ? OWN_DATA : OWN_INSTR;
            last_grant <= grant_data ? OWN_DATA : OWN_INSTR;
            if (grant_data) begin
              cmd_write       <= data_is_write;
              cmd_mask        <= data_is_write ? bus.data_write_mask_in : 4'h0;
              cmd_address     <= bus.data_address_in;
              cmd_write_value <= bus.data_write_value_in;
            end else begin
              cmd_write       <= 1'b0;
              cmd_mask        <= 4'h0;
              cmd_address     <= bus.instr_address_in;
              cmd_write_value <= 32'h0;
            end
          end
        end
        ST_BUSY: begin
          if (finish) begin
            // A real completion wins over a timeout landing on the same cycle.
            state      <= ST_DONE;
            tmo_cnt    <= 16'h0;
            resp_fault <= ~bus.mem_ready_in;
            if (owner == OWN_DATA) begin
              data_value <= resp_value;
            end else begin
              instr_value <= resp_value;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Command outputs are gated by busy so an asynchronous reset clears them at once.
  assign bus.mem_valid_out       = busy;
  assign bus.mem_write_out       = busy & cmd_write;
  assign bus.mem_write_mask_out  = busy ? cmd_mask : 4'h0;
  assign bus.mem_address_out     = busy ? cmd_address : 32'h0;
  assign bus.mem_write_value_out = busy ? cmd_write_value : 32'h0;

  assign bus.instr_ready_out      = done & (owner == OWN_INSTR);
  assign bus.instr_fault_out      = done & (owner == OWN_INSTR) & resp_fault;
  assign bus.instr_read_value_out = instr_value;
  assign bus.data_ready_out       = done & (owner == OWN_DATA);
  assign bus.data_fault_out       = done & (owner == OWN_DATA) & resp_fault;
  assign bus.data_read_value_out  = data_value;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Bench for rv32_bus_arbiter: directed scenarios plus randomized traffic scored
// against a transaction-level model of grant order, latency and responses.
module tb_rv32_bus_arbiter;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  rv32_bus_arbiter_if bus_if ();
  rv32_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_inputs();
    bus_if.instr_read_in       = 1'b0;
    bus_if.instr_address_in    = 32'h0;
    bus_if.data_read_in        = 1'b0;
    bus_if.data_write_in       = 1'b0;
    bus_if.data_write_mask_in  = 4'h0;
    bus_if.data_address_in     = 32'h0;
    bus_if.data_write_value_in = 32'h0;
    bus_if.mem_ready_in        = 1'b0;
    bus_if.mem_read_value_in   = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Zero-wait read from IDLE; returns at the negedge of the DONE cycle with requests dropped.
  task automatic quick_txn(input bit is_data, input logic [31:0] addr, input logic [31:0] rdata);
    if (is_data) begin
      bus_if.data_read_in = 1'b1; bus_if.data_address_in = addr;
    end else begin
      bus_if.instr_read_in = 1'b1; bus_if.instr_address_in = addr;
    end
    @(negedge clk);
    bus_if.mem_ready_in = 1'b1; bus_if.mem_read_value_in = rdata;
    @(negedge clk);
    bus_if.mem_ready_in = 1'b0; bus_if.instr_read_in = 1'b0; bus_if.data_read_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [69:0] got_bus;
    logic [67:0] got_rsp;
    clear_inputs();
    bus_if.mem_ready_in = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    got_bus = {bus_if.mem_valid_out, bus_if.mem_write_out, bus_if.mem_write_mask_out,
               bus_if.mem_address_out, bus_if.mem_write_value_out};
    got_rsp = {bus_if.instr_ready_out, bus_if.instr_fault_out, bus_if.data_ready_out,
               bus_if.data_fault_out, bus_if.instr_read_value_out, bus_if.data_read_value_out};
    n_cmp++;
    if (got_bus !== '0) begin n_fail++; $display("FAIL reset_bus got=%h exp=0", got_bus); end
    n_cmp++;
    if (got_rsp !== '0) begin n_fail++; $display("FAIL reset_rsp got=%h exp=0", got_rsp); end
    bus_if.mem_ready_in = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_if.mem_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_idle valid got=%b exp=0", bus_if.mem_valid_out); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    bus_if.instr_read_in = 1'b1; bus_if.instr_address_in = 32'h0000_0100;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.mem_valid_out, bus_if.mem_write_out, bus_if.mem_write_mask_out, bus_if.mem_address_out} !== {1'b1, 1'b0, 4'h0, 32'h100}) begin
      n_fail++; $display("FAIL fetch_cmd got=%b/%b/%h/%h exp=1/0/0/00000100", bus_if.mem_valid_out, bus_if.mem_write_out, bus_if.mem_write_mask_out, bus_if.mem_address_out);
    end
    bus_if.mem_ready_in = 1'b1; bus_if.mem_read_value_in = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.instr_ready_out, bus_if.instr_fault_out, bus_if.data_ready_out, bus_if.mem_valid_out} !== 4'b1000) begin
      n_fail++; $display("FAIL fetch_done rdy/flt/drdy/valid got=%b%b%b%b exp=1000", bus_if.instr_ready_out, bus_if.instr_fault_out, bus_if.data_ready_out, bus_if.mem_valid_out);
    end
    n_cmp++;
    if (bus_if.instr_read_value_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fetch_value got=%h exp=deadbeef", bus_if.instr_read_value_out); end
    bus_if.mem_ready_in = 1'b0; bus_if.instr_read_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_if.instr_ready_out !== 1'b0 || bus_if.instr_read_value_out !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL fetch_hold rdy=%b value=%h exp rdy=0 value=deadbeef", bus_if.instr_ready_out, bus_if.instr_read_value_out);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus_if.instr_read_in = 1'b1; bus_if.instr_address_in = 32'h300;
    bus_if.data_write_in = 1'b1; bus_if.data_write_mask_in = 4'b0011;
    bus_if.data_address_in = 32'h2000; bus_if.data_write_value_in = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.mem_write_out, bus_if.mem_write_mask_out, bus_if.mem_address_out, bus_if.mem_write_value_out} !== {1'b1, 4'b0011, 32'h2000, 32'h1234_5678}) begin
      n_fail++; $display("FAIL rr_first got=%b/%b/%h/%h exp=1/0011/00002000/12345678", bus_if.mem_write_out, bus_if.mem_write_mask_out, bus_if.mem_address_out, bus_if.mem_write_value_out);
    end
    bus_if.mem_ready_in = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.data_ready_out, bus_if.instr_ready_out} !== 2'b10) begin n_fail++; $display("FAIL rr_first_done d/i got=%b%b exp=10", bus_if.data_ready_out, bus_if.instr_ready_out); end
    bus_if.mem_ready_in = 1'b0; bus_if.data_write_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus_if.mem_valid_out, bus_if.mem_write_out, bus_if.mem_address_out} !== {1'b1, 1'b0, 32'h300}) begin
      n_fail++; $display("FAIL rr_second got=%b/%b/%h exp=1/0/00000300", bus_if.mem_valid_out, bus_if.mem_write_out, bus_if.mem_address_out);
    end
    bus_if.mem_ready_in = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.data_ready_out, bus_if.instr_ready_out} !== 2'b01) begin n_fail++; $display("FAIL rr_second_done d/i got=%b%b exp=01", bus_if.data_ready_out, bus_if.instr_ready_out); end
    bus_if.mem_ready_in = 1'b0;
    bus_if.instr_address_in = 32'h304;
    bus_if.data_read_in = 1'b1; bus_if.data_address_in = 32'h2004; bus_if.data_write_mask_in = 4'hF;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus_if.mem_valid_out, bus_if.mem_write_out, bus_if.mem_write_mask_out, bus_if.mem_address_out} !== {1'b1, 1'b0, 4'h0, 32'h2004}) begin
      n_fail++; $display("FAIL rr_third got=%b/%b/%b/%h exp=1/0/0000/00002004", bus_if.mem_valid_out, bus_if.mem_write_out, bus_if.mem_write_mask_out, bus_if.mem_address_out);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    quick_txn(1'b1, 32'h44, 32'hCAFE_F00D);
    bus_if.data_read_in = 1'b1; bus_if.data_address_in = 32'h48;
    @(negedge clk);
    n_cmp++;
    if (bus_if.mem_valid_out !== 1'b0 || bus_if.data_read_value_out !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL tmo_pre valid=%b value=%h exp valid=0 value=cafef00d", bus_if.mem_valid_out, bus_if.data_read_value_out);
    end
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_if.mem_valid_out !== 1'b1 || bus_if.data_ready_out !== 1'b0) begin
        n_fail++; $display("FAIL tmo_busy%0d valid=%b rdy=%b exp valid=1 rdy=0", i, bus_if.mem_valid_out, bus_if.data_ready_out);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus_if.data_ready_out, bus_if.data_fault_out, bus_if.mem_valid_out} !== 3'b110 || bus_if.data_read_value_out !== 32'h0) begin
      n_fail++; $display("FAIL tmo_done rdy/flt/valid=%b%b%b value=%h exp 110 value=0", bus_if.data_ready_out, bus_if.data_fault_out, bus_if.mem_valid_out, bus_if.data_read_value_out);
    end
    bus_if.data_read_in = 1'b0;
  endtask

  task automatic test_stable_cmd();
    do_reset();
    bus_if.instr_read_in = 1'b1; bus_if.instr_address_in = 32'h500;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_if.mem_valid_out !== 1'b1 || bus_if.mem_address_out !== 32'h500 || bus_if.instr_ready_out !== 1'b0) begin
        n_fail++; $display("FAIL stable_k%0d valid=%b addr=%h rdy=%b exp 1/00000500/0", k, bus_if.mem_valid_out, bus_if.mem_address_out, bus_if.instr_ready_out);
      end
      bus_if.instr_address_in = $urandom();
      bus_if.mem_ready_in = (k == 3);
      bus_if.mem_read_value_in = 32'h0BAD_F00D;
    end
    @(negedge clk);
    n_cmp++;
    if (bus_if.instr_ready_out !== 1'b1 || bus_if.instr_read_value_out !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL stable_done rdy=%b value=%h exp 1/0badf00d", bus_if.instr_ready_out, bus_if.instr_read_value_out);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    quick_txn(1'b0, 32'h600, 32'h1111_2222);
    bus_if.data_write_in = 1'b1; bus_if.data_write_mask_in = 4'hF; bus_if.data_address_in = 32'h700;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus_if.mem_valid_out !== 1'b1) begin n_fail++; $display("FAIL rstbusy_pre valid=%b exp=1", bus_if.mem_valid_out); end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus_if.mem_valid_out, bus_if.mem_address_out, bus_if.instr_read_value_out} !== 65'h0) begin
      n_fail++; $display("FAIL rstbusy_async valid=%b addr=%h ival=%h exp all 0", bus_if.mem_valid_out, bus_if.mem_address_out, bus_if.instr_read_value_out);
    end
    @(negedge clk);
    reset = 1'b1; bus_if.data_write_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_if.mem_valid_out, bus_if.instr_ready_out, bus_if.data_ready_out} !== 3'b000) begin
        n_fail++; $display("FAIL rstbusy_quiet%0d valid/irdy/drdy=%b%b%b exp 000", i, bus_if.mem_valid_out, bus_if.instr_ready_out, bus_if.data_ready_out);
      end
    end
    bus_if.instr_read_in = 1'b1; bus_if.instr_address_in = 32'h800;
    @(negedge clk);
    n_cmp++;
    if (bus_if.mem_valid_out !== 1'b1 || bus_if.mem_address_out !== 32'h800) begin
      n_fail++; $display("FAIL rstbusy_next valid=%b addr=%h exp 1/00000800", bus_if.mem_valid_out, bus_if.mem_address_out);
    end
    bus_if.mem_ready_in = 1'b1; bus_if.mem_read_value_in = 32'h7777_8888;
    @(negedge clk);
    n_cmp++;
    if (bus_if.instr_ready_out !== 1'b1 || bus_if.instr_read_value_out !== 32'h7777_8888) begin
      n_fail++; $display("FAIL rstbusy_next_done rdy=%b value=%h exp 1/77778888", bus_if.instr_ready_out, bus_if.instr_read_value_out);
    end
    clear_inputs();
  endtask

  task automatic test_stray_ready();
    do_reset();
    bus_if.mem_ready_in = 1'b1; bus_if.mem_read_value_in = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_if.mem_valid_out, bus_if.instr_ready_out, bus_if.data_ready_out} !== 3'b000 || bus_if.instr_read_value_out !== 32'h0) begin
        n_fail++; $display("FAIL stray_idle%0d valid/irdy/drdy=%b%b%b ival=%h exp 000/0", i, bus_if.mem_valid_out, bus_if.instr_ready_out, bus_if.data_ready_out, bus_if.instr_read_value_out);
      end
    end
    bus_if.instr_read_in = 1'b1; bus_if.instr_address_in = 32'h900;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus_if.instr_ready_out !== 1'b1 || bus_if.instr_read_value_out !== 32'h5555_AAAA) begin
      n_fail++; $display("FAIL stray_txn rdy=%b value=%h exp 1/5555aaaa", bus_if.instr_ready_out, bus_if.instr_read_value_out);
    end
    bus_if.instr_read_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_if.mem_valid_out, bus_if.instr_ready_out, bus_if.data_ready_out} !== 3'b000) begin
        n_fail++; $display("FAIL stray_after%0d valid/irdy/drdy=%b%b%b exp 000", i, bus_if.mem_valid_out, bus_if.instr_ready_out, bus_if.data_ready_out);
      end
    end
    clear_inputs();
  endtask

  task automatic test_drop_during_busy();
    do_reset();
    bus_if.data_read_in = 1'b1; bus_if.data_address_in = 32'hA00;
    @(negedge clk);
    bus_if.data_read_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_if.mem_valid_out !== 1'b1 || bus_if.mem_address_out !== 32'hA00) begin
      n_fail++; $display("FAIL drop_busy valid=%b addr=%h exp 1/00000a00", bus_if.mem_valid_out, bus_if.mem_address_out);
    end
    bus_if.mem_ready_in = 1'b1; bus_if.mem_read_value_in = 32'h1357_9BDF;
    @(negedge clk);
    n_cmp++;
    if (bus_if.data_ready_out !== 1'b1 || bus_if.data_read_value_out !== 32'h1357_9BDF) begin
      n_fail++; $display("FAIL drop_done rdy=%b value=%h exp 1/13579bdf", bus_if.data_ready_out, bus_if.data_read_value_out);
    end
    clear_inputs();
  endtask

  // Model: a pending side waits for the bus to be free; the first IDLE cycle holding a request
  // grants it, ties go to the side that did not win last, and a bus access completes after
  // waits+1 cycles or with a fault after TMO cycles.
  task automatic test_random();
    bit          pend[2];
    int          raise_cyc[2];
    logic        ewr[2];
    logic [3:0]  emask[2];
    logic [31:0] eaddr[2], ewd[2];
    int   last, own, free_cyc, es, mr, waits, k, exp_done, done_txn, guard;
    bit   active, exp_fault;
    logic [31:0] rsp, exp_val;
    logic [1:0]  exp_rdy;
    do_reset();
    pend[0] = 0; pend[1] = 0; raise_cyc[0] = 0; raise_cyc[1] = 0;
    last = 0; own = 0; free_cyc = cyc; active = 0; done_txn = 0; guard = 0;
    k = 0; waits = 0; exp_done = 0; exp_fault = 0; rsp = 0; exp_val = 0;
    while (done_txn < 120 && guard < 6000) begin
      @(negedge clk);
      guard++;
      if (!active && (pend[0] || pend[1])) begin
        mr = pend[0] ? raise_cyc[0] : raise_cyc[1];
        if (pend[0] && pend[1] && raise_cyc[1] < mr) mr = raise_cyc[1];
        es = ((mr > free_cyc) ? mr : free_cyc) + 1;
        if (cyc == es) begin
          own = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
          last = own;
          active = 1; k = 0;
          waits = $urandom_range(0, 5);
          rsp = $urandom();
          exp_fault = (waits >= TMO);
          exp_done = exp_fault ? cyc + TMO : cyc + waits + 1;
          exp_val = exp_fault ? 32'h0 : rsp;
        end
      end
      if (active && cyc < exp_done) begin
        n_cmp++;
        if (bus_if.mem_valid_out !== 1'b1 || bus_if.mem_write_out !== ewr[own] || bus_if.mem_write_mask_out !== emask[own] ||
            bus_if.mem_address_out !== eaddr[own] || (ewr[own] && bus_if.mem_write_value_out !== ewd[own]) ||
            bus_if.instr_ready_out !== 1'b0 || bus_if.data_ready_out !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_busy cyc=%0d got v/w/m/a/d=%b/%b/%h/%h/%h rdy=%b%b exp owner=%0d 1/%b/%h/%h/%h rdy=00", cyc,
                   bus_if.mem_valid_out, bus_if.mem_write_out, bus_if.mem_write_mask_out, bus_if.mem_address_out, bus_if.mem_write_value_out,
                   bus_if.instr_ready_out, bus_if.data_ready_out, own, ewr[own], emask[own], eaddr[own], ewd[own]);
        end
      end else if (active && cyc == exp_done) begin
        exp_rdy = (own == 1) ? 2'b01 : 2'b10;
        n_cmp++;
        if ({bus_if.instr_ready_out, bus_if.data_ready_out} !== exp_rdy ||
            {bus_if.instr_fault_out, bus_if.data_fault_out} !== (exp_fault ? exp_rdy : 2'b00) ||
            bus_if.mem_valid_out !== 1'b0 ||
            ((own == 1) ? bus_if.data_read_value_out : bus_if.instr_read_value_out) !== exp_val) begin
          n_fail++;
          $display("FAIL rand_done cyc=%0d got rdy=%b%b flt=%b%b valid=%b ival=%h dval=%h exp rdy=%b fault=%b value=%h", cyc,
                   bus_if.instr_ready_out, bus_if.data_ready_out, bus_if.instr_fault_out, bus_if.data_fault_out,
                   bus_if.mem_valid_out, bus_if.instr_read_value_out, bus_if.data_read_value_out, exp_rdy, exp_fault, exp_val);
        end
        active = 0; free_cyc = cyc + 1; pend[own] = 0; done_txn++;
        if (own == 1) begin bus_if.data_read_in = 1'b0; bus_if.data_write_in = 1'b0; end
        else bus_if.instr_read_in = 1'b0;
      end else begin
        n_cmp++;
        if ({bus_if.mem_valid_out, bus_if.instr_ready_out, bus_if.data_ready_out} !== 3'b000) begin
          n_fail++; $display("FAIL rand_idle cyc=%0d valid/irdy/drdy=%b%b%b exp 000", cyc, bus_if.mem_valid_out, bus_if.instr_ready_out, bus_if.data_ready_out);
        end
      end
      if (active && cyc < exp_done) begin
        bus_if.mem_ready_in = (k == waits);
        bus_if.mem_read_value_in = (k == waits) ? rsp : $urandom();
        k++;
      end else begin
        bus_if.mem_ready_in = ($urandom_range(0, 3) == 0);
        bus_if.mem_read_value_in = $urandom();
      end
      for (int s = 0; s < 2; s++) begin
        if (!pend[s] && $urandom_range(0, 2) == 0) begin
          pend[s] = 1; raise_cyc[s] = cyc; eaddr[s] = $urandom();
          if (s == 0) begin
            ewr[0] = 1'b0; emask[0] = 4'h0; ewd[0] = 32'h0;
            bus_if.instr_read_in = 1'b1; bus_if.instr_address_in = eaddr[0];
          end else begin
            int   kind;
            logic [3:0] mval;
            kind = $urandom_range(0, 2);
            mval = 4'($urandom_range(0, 15));
            ewr[1] = (kind != 0); emask[1] = (kind != 0) ? mval : 4'h0; ewd[1] = $urandom();
            bus_if.data_read_in = (kind != 1); bus_if.data_write_in = (kind != 0);
            bus_if.data_write_mask_in = mval; bus_if.data_address_in = eaddr[1];
            bus_if.data_write_value_in = ewd[1];
          end
        end
      end
    end
    if (done_txn < 120) begin
      n_cmp++; n_fail++;
      $display("FAIL rand_budget completed=%0d required=120", done_txn);
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_timeout();
    test_stable_cmd();
    test_reset_mid_busy();
    test_stray_ready();
    test_drop_during_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
